// File: rtl/c2c_sym_unpacker_if.sv
// Bundle of the symbol-FIFO read side and the word-level output side of the unpacker.
// No logic of its own; latency is whatever the attached unpacker implements.
// Backpressure: OUT_READY gates the unpacker's FIFO pops while a word is held.
interface c2c_sym_unpacker_if #(
    parameter int WORD_NIB = 8,
    parameter int ERR_W    = 8
);
    logic [4:0]            FIFO_RDATA;
    logic                  FIFO_EMPTY;
    logic                  FIFO_RDEN;
    logic [4*WORD_NIB-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  ERR;
    logic [ERR_W-1:0]      ERR_CNT;

    // Unpacker side: consumes FIFO symbols, produces words and error reports.
    modport slave (
        input  FIFO_RDATA, FIFO_EMPTY, OUT_READY,
        output FIFO_RDEN, OUT_DATA, OUT_VALID, ERR, ERR_CNT
    );

    // Environment side: owns the FIFO head and the downstream ready.
    modport master (
        output FIFO_RDATA, FIFO_EMPTY, OUT_READY,
        input  FIFO_RDEN, OUT_DATA, OUT_VALID, ERR, ERR_CNT
    );
endinterface

// File: rtl/c2c_sym_unpacker.sv
// Drains 5-bit {SOF,nibble} symbols from a show-ahead FIFO and assembles WORD_NIB-nibble words.
// Latency: word valid the cycle after its last nibble is popped; one symbol per cycle sustained.
// Backpressure: while a word waits for OUT_READY no symbol is popped; the handshake cycle may pop.
module c2c_sym_unpacker #(
    parameter int WORD_NIB = 8,
    parameter int ERR_W    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    c2c_sym_unpacker_if.slave     bus
);

    localparam int IDX_W = $clog2(WORD_NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NIB - 1);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*WORD_NIB-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [ERR_W-1:0]      cnt_q, cnt_d;
    logic                  pop;
    logic                  sym_sof;
    logic [3:0]            sym_nib;

    assign sym_sof = bus.FIFO_RDATA[4];
    assign sym_nib = bus.FIFO_RDATA[3:0];

    // Pop decision, framing FSM, nibble placement and error counting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        pop     = !RST && !bus.FIFO_EMPTY && (state_q != S_HOLD || bus.OUT_READY);

        case (state_q)
            S_COLLECT: begin
                if (pop) begin
                    if (sym_sof) begin
                        // Premature SOF: drop the partial word and restart on this symbol.
                        err_d       = 1'b1;
                        data_d[3:0] = sym_nib;
                        idx_d       = IDX_W'(1);
                    end else begin
                        data_d[{idx_q, 2'b00} +: 4] = sym_nib;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_HOLD;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: begin
                // HUNT, or HOLD in its handshake cycle, which then behaves like HUNT.
                if (state_q == S_HOLD && bus.OUT_READY) begin
                    state_d = S_HUNT;
                end
                if (pop) begin
                    if (sym_sof) begin
                        data_d[3:0] = sym_nib;
                        idx_d       = IDX_W'(1);
                        state_d     = S_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        if (err_d && cnt_q != '1) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    // State, assembly register and error reporting; reset discards any partial or held word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_HUNT;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.FIFO_RDEN = pop;
    assign bus.OUT_DATA  = data_q;
    assign bus.OUT_VALID = (state_q == S_HOLD);
    assign bus.ERR       = err_q;
    assign bus.ERR_CNT   = cnt_q;

endmodule
